// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the asynchronous FIFO slice.
//   cnt_e     - occupancy state of the two-entry read-side output buffer
//   gray2bin  - gray-to-binary conversion for pointers up to 32 bits wide
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } cnt_e;

  // Callers zero-extend a narrower pointer into g and truncate the result.
  // Zero upper bits contribute nothing to the XOR-prefix, so this one
  // function serves every pointer width.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: read-side first-word-fall-through stage of the async FIFO.
// Turns the FIFO's empty/increment interface into a valid/ready stream
// using a two-entry buffer (head + skid), so rinc never depends on m_ready.
// Also reports the registered read-side fill level.
//   rclk, rrst_n  read clock, asynchronous active-low reset
//   rempty        registered FIFO empty flag
//   rdata         memory data at current raddr (valid when rempty=0)
//   rptr          gray read pointer
//   rq2_wptr      gray write pointer synchronized into rclk
//   rinc          pop request to the FIFO
//   m_valid/m_data/m_ready  output stream
//   m_level       words in FIFO plus words held here (1-cycle latency)
module fifo_rd_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned DSIZE    = 8,
  parameter int unsigned ADDRSIZE = 6
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  input  logic [ADDRSIZE:0]     rptr,
  input  logic [ADDRSIZE:0]     rq2_wptr,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DSIZE-1:0]      m_data,
  input  logic                  m_ready,
  output logic [ADDRSIZE+1:0]   m_level
);

  localparam int unsigned PW = ADDRSIZE + 1;
  localparam int unsigned LW = ADDRSIZE + 2;

  cnt_e              cnt_q, cnt_d;
  logic [DSIZE-1:0]  head_q, head_d;
  logic [DSIZE-1:0]  skid_q, skid_d;
  logic [LW-1:0]     level_q, level_d;

  logic              push, pop;
  logic [PW-1:0]     wbin, rbin, occ;

  // Depends only on registered state and rempty, never on m_ready.
  assign rinc    = ~rempty & (cnt_q != TWO);
  assign push    = rinc;
  assign m_valid = (cnt_q != EMPTY);
  assign pop     = m_valid & m_ready;
  assign m_data  = head_q;
  assign m_level = level_q;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    unique case (cnt_q)
      EMPTY: begin
        if (push) begin
          cnt_d  = ONE;
          head_d = rdata;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = rdata;
        end else if (push) begin
          cnt_d  = TWO;
          skid_d = rdata;
        end else if (pop) begin
          cnt_d  = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          cnt_d  = ONE;
          head_d = skid_q;
        end
      end
      default: cnt_d = EMPTY;
    endcase
  end

  // Modular subtraction in PW bits handles pointer wrap-around.
  assign wbin    = PW'(gray2bin(32'(rq2_wptr)));
  assign rbin    = PW'(gray2bin(32'(rptr)));
  assign occ     = wbin - rbin;
  assign level_d = LW'(occ) + LW'(cnt_q);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_q   <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      level_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      level_q <= level_d;
    end
  end

endmodule
